// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t    : controller state encoding (IDLE / RUN)
//   calc_cnt_w : width of the bit counter for a given operand width
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter must hold 0..width-1; never narrower than one bit.
    function automatic int calc_cnt_w(input int width);
        if (width <= 2) return 1;
        return $clog2(width);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Single-bit combinational full adder, the datapath cell reused every cycle
// by the serial controller.
//   i_a, i_b : operand bits
//   i_c      : carry in
//   o_sum    : sum bit
//   o_co     : carry out
module fa_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_co
);

    logic w_p;

    assign w_p   = i_a ^ i_b;
    assign o_sum = w_p ^ i_c;
    assign o_co  = (i_a & i_b) | (w_p & i_c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in,
// LSB first, one bit per clock, through a single full-adder cell.
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : request, accepted only in IDLE
//   a, b, cin  : operands, captured on the accepted start edge
//   busy       : addition in progress
//   done       : one-cycle pulse, sum/cout just updated
//   sum, cout  : result, held until the next completion
//
// state | meaning
// IDLE  | waiting for start; result registers hold last answer
// RUN   | one operand bit consumed per edge; finishes on bit WIDTH-1
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CNT_W = calc_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_s_next;

    fa_bit u_fa (
        .i_a   (r_a_sh[0]),
        .i_b   (r_b_sh[0]),
        .i_c   (r_carry),
        .o_sum (w_s),
        .o_co  (w_co)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
    assign w_s_next = {w_s, r_s_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_s_sh  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_carry <= w_co;
                    r_s_sh  <= w_s_next;
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    if (r_cnt == LAST) begin
                        // Counter parks at zero so it never exceeds WIDTH-1.
                        r_cnt   <= '0;
                        r_sum   <= w_s_next;
                        r_cout  <= w_co;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        cin32 = 1'b0;
    logic        busy32, done32, cout32;
    logic [31:0] sum32;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    serial_adder_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    // Drive a start for one edge, then count edges until done (bounded).
    // lat = number of edges after the start edge at which done is observed.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        output int lat);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #3;
        total++;
        if ({busy, done, sum, cout} !== 10'b0) begin
            bad++; $display("FAIL reset8: got %h want 0", {busy, done, sum, cout});
        end
        total++;
        if ({busy4, done4, sum4, cout4, busy32, done32, sum32, cout32} !== 41'b0) begin
            bad++; $display("FAIL reset_sweep_duts: outputs not cleared");
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++; $display("FAIL idle_after_reset: busy/done got %b want 00", {busy, done});
        end
    endtask

    task automatic test_basic;
        int busy_bad;
        busy_bad = 0;
        @(negedge clk);
        a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int e = 0; e < 8; e++) begin
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
            @(negedge clk);
        end
        total++;
        if (busy_bad != 0) begin
            bad++; $display("FAIL basic_busy_window: got %0d bad cycles want 0", busy_bad);
        end
        total++;
        if ({done, busy} !== 2'b10) begin
            bad++; $display("FAIL basic_done_edge8: done/busy got %b want 10", {done, busy});
        end
        total++;
        if ({cout, sum} !== 9'h08D) begin
            bad++; $display("FAIL basic_result: got %h want 08d", {cout, sum});
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL basic_done_pulse_width: done got %b want 0", done);
        end
    endtask

    task automatic test_carry;
        int lat;
        run8(8'hFF, 8'h01, 1'b0, lat);
        total++;
        if ({cout, sum} !== 9'h100 || lat != 8) begin
            bad++; $display("FAIL carry_ff_01: got %h lat %0d want 100 lat 8", {cout, sum}, lat);
        end
        run8(8'hFF, 8'h00, 1'b1, lat);
        total++;
        if ({cout, sum} !== 9'h100 || lat != 8) begin
            bad++; $display("FAIL carry_ff_cin: got %h lat %0d want 100 lat 8", {cout, sum}, lat);
        end
        run8(8'hA5, 8'h5A, 1'b1, lat);
        total++;
        if ({cout, sum} !== 9'h100) begin
            bad++; $display("FAIL carry_a5_5a_cin: got %h want 100", {cout, sum});
        end
        run8(8'h80, 8'h80, 1'b0, lat);
        total++;
        if ({cout, sum} !== 9'h100) begin
            bad++; $display("FAIL carry_msb: got %h want 100", {cout, sum});
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);                  // edge 0 taken
        start = 1'b0;
        @(negedge clk);                  // edge 1
        @(negedge clk);                  // edge 2
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);                  // edge 3 ignores it
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != 8) begin
            bad++; $display("FAIL busy_start_latency: got %0d want 8", lat);
        end
        total++;
        if ({cout, sum} !== 9'h030) begin
            bad++; $display("FAIL busy_start_result: got %h want 030", {cout, sum});
        end
        // Result of 0x10+0x20 stays; start in done cycle begins 0x01+0x01 run.
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);                  // edge 9 accepts
        start = 1'b0;
        begin
            int hold_bad;
            hold_bad = 0;
            for (int e = 9; e < 17; e++) begin
                if (sum !== 8'h30 || cout !== 1'b0 || done !== 1'b0 || busy !== 1'b1)
                    hold_bad++;
                @(negedge clk);
            end
            total++;
            if (hold_bad != 0) begin
                bad++; $display("FAIL b2b_hold_old: got %0d bad cycles want 0", hold_bad);
            end
        end
        total++;
        if (done !== 1'b1 || {cout, sum} !== 9'h002) begin
            bad++; $display("FAIL b2b_new_result: done %b sum %h want 1 002", done, {cout, sum});
        end
    endtask

    task automatic test_reset_mid_op;
        int lat;
        int seen_done;
        @(negedge clk);
        a = 8'h44; b = 8'h11; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, sum, cout} !== 10'b0) begin
            bad++; $display("FAIL reset_mid_op: got %h want 0", {busy, done, sum, cout});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        total++;
        if (seen_done != 0) begin
            bad++; $display("FAIL reset_no_done: got %0d active cycles want 0", seen_done);
        end
        run8(8'h7F, 8'h01, 1'b0, lat);
        total++;
        if ({cout, sum} !== 9'h080 || lat != 8) begin
            bad++; $display("FAIL after_reset_run: got %h lat %0d want 080 lat 8", {cout, sum}, lat);
        end
    endtask

    task automatic test_sweep4;
        int lat;
        logic [4:0] exp;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            exp = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            lat = 0;
            while (!done4 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            total++;
            if (lat != 4 || {cout4, sum4} !== exp) begin
                bad++;
                $display("FAIL sweep4 #%0d: got %h lat %0d want %h lat 4", i, {cout4, sum4}, lat, exp);
            end
        end
    endtask

    task automatic test_sweep32;
        int lat;
        logic [32:0] exp;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
            if (i == 0) begin a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1; end
            exp = {1'b0, a32} + {1'b0, b32} + {32'b0, cin32};
            start32 = 1'b1;
            @(negedge clk);
            start32 = 1'b0;
            lat = 0;
            while (!done32 && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            total++;
            if (lat != 32 || {cout32, sum32} !== exp) begin
                bad++;
                $display("FAIL sweep32 #%0d: got %h lat %0d want %h lat 32", i, {cout32, sum32}, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_start_while_busy;
        test_reset_mid_op;
        test_sweep4;
        test_sweep32;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. It sequences one single-bit full-adder cell over WIDTH-bit operands, LSB first, one bit per clock.
- A registered carry links successive bits.
- Used wherever area matters more than latency. It reuses the team's full-adder datapath style in a clocked, handshaked wrapper.
- Interface is start/busy/done. The result is held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk    input   1      rising-edge clock; the only clock.
- rst_n  input   1      asynchronous, active-low reset.
- start  input   1      request; sampled only in IDLE.
- a      input   WIDTH  operand A; captured on the accepted start edge.
- b      input   WIDTH  operand B; captured on the accepted start edge.
- cin    input   1      carry-in; captured on the accepted start edge.
- busy   output  1      high while an addition is in progress.
- done   output  1      one-cycle registered pulse; the result is valid.
- sum    output  WIDTH  result register; held between operations.
- cout   output  1      final carry-out; held between operations.

Behaviour:
- Reset (rst_n low, asynchronous, any state including mid-operation):
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0.
  - Shift registers, carry register and bit counter are all cleared.
  - Any in-flight operation is discarded; no done is issued for it.
- States: IDLE, RUN.
- IDLE:
  - On a clk edge with start = 1:
    - a_sh <= a, b_sh <= b, carry <= cin, cnt <= 0.
    - s_sh <= 0, busy <= 1, state -> RUN.
  - start = 0: remain in IDLE; all outputs hold.
- RUN, every edge:
  - Full-adder cell inputs: a_sh[0], b_sh[0], carry.
  - carry <= cell carry-out.
  - s_sh <= {cell sum, s_sh[WIDTH-1:1]}, so sum enters at the MSB and shifts right.
  - a_sh and b_sh shift right by 1.
  - cnt <= cnt + 1.
- RUN, the edge where cnt == WIDTH-1 (the last bit):
  - sum <= final shifted value, including this bit.
  - cout <= cell carry-out.
  - done <= 1, busy <= 0, state -> IDLE.
- Latency: start sampled at edge k gives the last bit at edge k+WIDTH.
  - done is high for exactly the cycle between edges k+WIDTH and k+WIDTH+1.
  - busy is high between edges k and k+WIDTH.
- done is cleared on every edge where it is not being set.
- start while busy = 1: ignored, with no effect on operands, state or outputs. The request is not queued.
- start in the cycle where done = 1: the state is IDLE, so it is accepted.
  - That edge clears done and starts a new run. This gives a throughput of one result per WIDTH+1 cycles.
  - sum and cout keep the old result until the new run completes.
- sum and cout change only at completion edges or reset. They never show partial results.
- Arithmetic is unsigned modulo 2^WIDTH, with overflow reported in cout.
  - {cout, sum} == a + b + cin, computed at full WIDTH+1 bits.
- Counter: cnt never exceeds WIDTH-1. It is not advanced in IDLE.
- Operand inputs are don't-care except on the accepted start edge.

Decomposition:
- Shared package serial_adder_pkg:
  - State enum: IDLE = 1'b0, RUN = 1'b1.
  - Function computing CNT_W.
- One sub-module: fa_bit.
  - Purely combinational single-bit full adder: sum = a^b^c, co = ab | (a^b)c.
  - No gate delays; synthesizable.
  - Instantiated once in serial_adder_ctrl.
- All state, shift and counter logic lives in serial_adder_ctrl.

Test Plan:
- Basic add: WIDTH=8, a=0x5A, b=0x33, cin=0, start at edge 0.
  - busy high for edges 0..8; done pulse after edge 8.
  - sum=0x8D, cout=0.
- Full carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Separately, a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Start while busy: start run with 0x10+0x20. Pulse start with a=0xFF, b=0xFF at edge 3.
  - Result is still sum=0x30, cout=0; done at edge 8 only.
- Back-to-back: assert start with 0x01+0x01 in the done cycle of the previous run.
  - The new run is accepted.
  - The old sum holds through edges 9..16; the new sum=0x02 with done after edge 17.
- Reset mid-op: drop rst_n asynchronously at cycle 4 of a run.
  - busy, done, sum and cout go to 0 immediately; no done pulse.
  - After release, a fresh 0x7F+0x01 run gives sum=0x80, cout=0.
- Parameter sweep: WIDTH=4 and WIDTH=32 with random operands and cin (≥1000 each).
  - {cout, sum} == a+b+cin.
  - done arrives exactly WIDTH edges after the start edge.
